// File: rtl/bus_master_if_if.sv
// Shared word bus as seen by one initiator: arbitration handshake, address phase
// and the muxed slave return path.
interface bus_master_if_if;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    logic              bus_req_n;
    logic              bus_grnt_n;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_n;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_n;

    modport master (
        output bus_req_n, bus_addr, bus_as_n, bus_rw, bus_wr_data,
        input  bus_grnt_n, bus_rd_data, bus_rdy_n
    );

    modport slave (
        input  bus_req_n, bus_addr, bus_as_n, bus_rw, bus_wr_data,
        output bus_grnt_n, bus_rd_data, bus_rdy_n
    );
endinterface

// File: rtl/bus_master_if.sv
// Bus initiator: takes one core access, arbitrates for the bus, strobes the address
// and returns read data to the core, aborting on a ready timeout.
module bus_master_if #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8,
    localparam int unsigned ADDR_W = 30,
    localparam int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_as_n,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_rw,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic              core_stall,
    input  logic              core_flush,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_busy,
    output logic              core_err,
    bus_master_if_if.master   bus
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

    // Last ACCESS cycle index that may still see ready before the access is aborted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic              req_n_q, req_n_d;
    logic              as_n_q, as_n_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_n_q <= 1'b1;
            as_n_q  <= 1'b1;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_n_q <= req_n_d;
            as_n_q  <= as_n_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next-output and core_busy decode
    always_comb begin
        state_d   = state_q;
        req_n_d   = req_n_q;
        as_n_d    = 1'b1;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        core_busy = 1'b0;

        case (state_q)
            IDLE: begin
                if (!core_as_n && !core_flush) begin
                    core_busy = 1'b1;
                    addr_d    = core_addr;
                    rw_d      = core_rw;
                    wdata_d   = core_wr_data;
                    req_n_d   = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                core_busy = 1'b1;
                if (!bus.bus_grnt_n) begin
                    as_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                core_busy = 1'b1;
                // Ready wins over an expiring counter in the same cycle.
                if (!bus.bus_rdy_n || cnt_q == CNT_LAST) begin
                    req_n_d = 1'b1;
                    state_d = core_stall ? STALL : IDLE;
                    if (!bus.bus_rdy_n) begin
                        if (rw_q) begin
                            rdata_d = bus.bus_rd_data;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (rw_q) begin
                            rdata_d = '0;
                        end
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STALL: begin
                if (!core_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.bus_req_n   = req_n_q;
    assign bus.bus_as_n    = as_n_q;
    assign bus.bus_rw      = rw_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_wr_data = wdata_q;
    assign core_rd_data    = rdata_q;
    assign core_err        = err_q;

endmodule
